mem_lsu: RTL and testbench

Memory-access pipeline stage of the 5-stage MIPS core, sitting between EX and WB. It registers the EX result bus and issues loads and stores to the data memory over a req/addr_ok/data_ok handshake. It holds the pipeline via `stallreq_mem` until each access completes, then extracts and extends load data. It produces `mem_to_wb_bus`, the HI/LO side bus `mem_to_wb1`, and the MEM→ID forwarding bus.

---
 rtl/mem_lsu_pkg.sv | 59 +++++
 rtl/mem_load_ext.sv | 35 +++
 rtl/mem_lsu.sv | 185 ++++++++++++++++++
 tb/tb_mem_lsu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared widths, mem_op encodings, FSM states and address helpers
//    for the MEM stage.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package mem_lsu_pkg;

   localparam int EX_TO_MEM_WD = 107;
   localparam int MEM_TO_WB_WD = 70;
   localparam int STALL_WD     = 6;

   // Stall vector bit values
   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   // mem_op encodings
   localparam logic [2:0] OP_LW  = 3'd0;
   localparam logic [2:0] OP_LB  = 3'd1;
   localparam logic [2:0] OP_LBU = 3'd2;
   localparam logic [2:0] OP_LH  = 3'd3;
   localparam logic [2:0] OP_LHU = 3'd4;
   localparam logic [2:0] OP_SW  = 3'd5;
   localparam logic [2:0] OP_SB  = 3'd6;
   localparam logic [2:0] OP_SH  = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_RESP = 2'd2
   } lsu_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic        mem_en;
      logic        mem_we;
      logic [2:0]  mem_op;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic [31:0] alu_result;
      logic [31:0] store_data;
   } ex_to_mem_t;

   // Word accesses drop addr[1:0], halfword accesses drop addr[0].
   function automatic logic [31:0] align_addr(input logic [2:0] op, input logic [31:0] a);
      case (op)
         OP_LW, OP_SW:         align_addr = {a[31:2], 2'b00};
         OP_LH, OP_LHU, OP_SH: align_addr = {a[31:1], 1'b0};
         default:              align_addr = a;
      endcase
   endfunction

   function automatic logic misaligned(input logic [2:0] op, input logic [31:0] a);
      case (op)
         OP_LW, OP_SW:         misaligned = |a[1:0];
         OP_LH, OP_LHU, OP_SH: misaligned = a[0];
         default:              misaligned = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mem_load_ext.sv
// mem_load_ext: lane select and sign/zero extension of a load word.
// Latency: purely combinational.
// Backpressure: none.
// Ports: rdata (raw word), addr_lo (byte offset), mem_op (load type) -> result.
module mem_load_ext
   import mem_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr_lo,
   input  logic [2:0]  mem_op,
   output logic [31:0] result
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (addr_lo)
         2'd0:    byte_sel = rdata[7:0];
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         default: byte_sel = rdata[31:24];
      endcase
      half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

      case (mem_op)
         OP_LB:   result = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  result = {24'd0, byte_sel};
         OP_LH:   result = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  result = {16'd0, half_sel};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM stage; registers the EX bus, runs the data-SRAM req/addr_ok/data_ok
//    handshake and extracts load data for WB and MEM->ID forwarding.
// Latency: store 0 stall cycles with immediate addr_ok; load 1 stall cycle best case,
//    plus 1 per cycle without addr_ok/data_ok.
// Backpressure: stallreq_mem holds the pipeline until the access completes; a WB stall
//    after completion holds the result from ld_buf without re-issuing.
// Ports: clk, rst (async active-low), stall[5:0], ex_to_mem_bus, ex_to_mem1, data_sram_*,
//    stallreq_mem, mem_to_wb_bus, mem_to_wb1, mem_to_id_bus.
// Option: MEM_UNALIGNED_EXC_EN adds mem_adel/mem_ades and suppresses misaligned accesses.
module mem_lsu
   import mem_lsu_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   input  logic [65:0]             ex_to_mem1,
   output logic                    data_sram_req,
   output logic                    data_sram_wr,
   output logic [3:0]              data_sram_wstrb,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata,
   input  logic                    data_sram_addr_ok,
   input  logic                    data_sram_data_ok,
   input  logic [31:0]             data_sram_rdata,
   output logic                    stallreq_mem,
   output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
   output logic [65:0]             mem_to_wb1,
`ifdef MEM_UNALIGNED_EXC_EN
   output logic                    mem_adel,
   output logic                    mem_ades,
`endif
   output logic [37:0]             mem_to_id_bus
);

   ex_to_mem_t  ex_q, ex_d;
   logic [65:0] hilo_q, hilo_d;
   lsu_state_e  state_q, state_d;
   logic        done_q, done_d;
   logic [31:0] ld_buf_q, ld_buf_d;

   logic        capture, bubble, misalign, access;
   logic        rf_we_eff;
   logic [31:0] ld_src, ld_result, rf_wdata;
   logic        unused_stall;

   assign unused_stall = ^{stall[5], stall[2:0]};

   assign capture = (stall[3] == NO_STOP);
   assign bubble  = (stall[3] == STOP) && (stall[4] == NO_STOP);

`ifdef MEM_UNALIGNED_EXC_EN
   assign misalign = ex_q.mem_en & misaligned(ex_q.mem_op, ex_q.alu_result);
   assign mem_adel = misalign & ~ex_q.mem_we;
   assign mem_ades = misalign &  ex_q.mem_we;
`else
   assign misalign = 1'b0;
`endif

   // A misaligned access under the exception option never touches the SRAM.
   assign access = ex_q.mem_en & ~done_q & ~misalign;

   // Input register
   always_comb begin
      ex_d   = ex_q;
      hilo_d = hilo_q;
      if (bubble) begin
         ex_d   = '0;
         hilo_d = '0;
      end else if (capture) begin
         ex_d   = ex_to_mem_bus;
         hilo_d = ex_to_mem1;
      end
   end

   // Handshake FSM
   always_comb begin
      state_d       = state_q;
      done_d        = done_q;
      ld_buf_d      = ld_buf_q;
      data_sram_req = 1'b0;
      case (state_q)
         ST_IDLE: begin
            data_sram_req = access;
            if (access) begin
               if (data_sram_addr_ok) begin
                  if (ex_q.mem_we) done_d  = 1'b1;
                  else             state_d = ST_RESP;
               end else begin
                  state_d = ST_REQ;
               end
            end
            if (misalign) done_d = 1'b1;
         end
         ST_REQ: begin
            data_sram_req = 1'b1;
            if (data_sram_addr_ok) begin
               if (ex_q.mem_we) begin
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_RESP;
               end
            end
         end
         ST_RESP: begin
            if (data_sram_data_ok) begin
               ld_buf_d = data_sram_rdata;
               done_d   = 1'b1;
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      // A new entry (or bubble) starts with a clean completion record.
      if (bubble || capture) begin
         done_d   = 1'b0;
         ld_buf_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q     <= '0;
         hilo_q   <= '0;
         state_q  <= ST_IDLE;
         done_q   <= 1'b0;
         ld_buf_q <= '0;
      end else begin
         ex_q     <= ex_d;
         hilo_q   <= hilo_d;
         state_q  <= state_d;
         done_q   <= done_d;
         ld_buf_q <= ld_buf_d;
      end
   end

   // Request side, combinational from the register so it stays stable while held
   assign data_sram_wr   = ex_q.mem_we;
   assign data_sram_addr = align_addr(ex_q.mem_op, ex_q.alu_result);

   always_comb begin
      case (ex_q.mem_op)
         OP_SB: begin
            data_sram_wstrb = 4'b0001 << data_sram_addr[1:0];
            data_sram_wdata = {4{ex_q.store_data[7:0]}};
         end
         OP_SH: begin
            data_sram_wstrb = data_sram_addr[1] ? 4'b1100 : 4'b0011;
            data_sram_wdata = {2{ex_q.store_data[15:0]}};
         end
         OP_SW: begin
            data_sram_wstrb = 4'b1111;
            data_sram_wdata = ex_q.store_data;
         end
         default: begin
            data_sram_wstrb = 4'b0000;
            data_sram_wdata = ex_q.store_data;
         end
      endcase
   end

   assign stallreq_mem = ex_q.mem_en & ~(done_q | misalign
                                       | ((state_q == ST_RESP) & data_sram_data_ok)
                                       | (ex_q.mem_we & data_sram_addr_ok & data_sram_req));

   // Load data comes straight from the SRAM in its data_ok cycle, else from ld_buf.
   assign ld_src = ((state_q == ST_RESP) && data_sram_data_ok) ? data_sram_rdata : ld_buf_q;

   mem_load_ext u_load_ext (
      .rdata   (ld_src),
      .addr_lo (data_sram_addr[1:0]),
      .mem_op  (ex_q.mem_op),
      .result  (ld_result)
   );

   assign rf_wdata  = (ex_q.mem_en & ~ex_q.mem_we) ? ld_result : ex_q.alu_result;
   assign rf_we_eff = ex_q.rf_we & ~misalign;

   assign mem_to_wb_bus = {ex_q.pc, rf_we_eff, ex_q.rf_waddr, rf_wdata};
   assign mem_to_wb1    = hilo_q;
   // Pending loads must not forward the stale ALU/ld_buf value.
   assign mem_to_id_bus = {rf_we_eff & ~stallreq_mem, ex_q.rf_waddr, rf_wdata};

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed + randomized bench for mem_lsu with a behavioural memory model.
// Latency: n/a.
// Backpressure: the bench drives the stall vector from stallreq_mem and a WB-stop control.
module tb_mem_lsu;
   import mem_lsu_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [STALL_WD-1:0]     stall;
   logic [EX_TO_MEM_WD-1:0] ex_bus;
   logic [65:0]             ex1;
   logic                    req, wr, addr_ok, data_ok, stallreq;
   logic [3:0]              wstrb;
   logic [31:0]             addr, wdata, rdata;
   logic [MEM_TO_WB_WD-1:0] wb_bus;
   logic [65:0]             wb1;
   logic [37:0]             id_bus;
   logic                    wb_stop, bubble;
`ifdef MEM_UNALIGNED_EXC_EN
   logic                    adel, ades;
`endif

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   assign stall = (stallreq | wb_stop) ? 6'b011111 : (bubble ? 6'b001000 : 6'b000000);

   mem_lsu dut (
      .clk               (clk),
      .rst               (rst),
      .stall             (stall),
      .ex_to_mem_bus     (ex_bus),
      .ex_to_mem1        (ex1),
      .data_sram_req     (req),
      .data_sram_wr      (wr),
      .data_sram_wstrb   (wstrb),
      .data_sram_addr    (addr),
      .data_sram_wdata   (wdata),
      .data_sram_addr_ok (addr_ok),
      .data_sram_data_ok (data_ok),
      .data_sram_rdata   (rdata),
      .stallreq_mem      (stallreq),
      .mem_to_wb_bus     (wb_bus),
      .mem_to_wb1        (wb1),
`ifdef MEM_UNALIGNED_EXC_EN
      .mem_adel          (adel),
      .mem_ades          (ades),
`endif
      .mem_to_id_bus     (id_bus)
   );

   task automatic check(input string tag, input logic [69:0] obs, input logic [69:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---- reference model (plain arithmetic on the architectural rules) ----
   function automatic logic [31:0] m_addr(input logic [2:0] op, input logic [31:0] a);
      if (op == OP_LW || op == OP_SW) return a - (a % 4);
      if (op == OP_LH || op == OP_LHU || op == OP_SH) return a - (a % 2);
      return a;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] op, input logic [31:0] w, input logic [31:0] a);
      logic [31:0] b, h;
      b = (w >> (8 * (a % 4))) % 256;
      h = (w >> (16 * ((a / 2) % 2))) % 65536;
      case (op)
         OP_LB:   return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         OP_LBU:  return b;
         OP_LH:   return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         OP_LHU:  return h;
         default: return w;
      endcase
   endfunction

   function automatic logic [3:0] m_strb(input logic [2:0] op, input logic [31:0] a);
      if (op == OP_SB) return 4'(1 << (a % 4));
      if (op == OP_SH) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
      return 4'd15;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] op, input logic [31:0] sd);
      if (op == OP_SB) return (sd % 256) * 32'h0101_0101;
      if (op == OP_SH) return (sd % 65536) * 32'h0001_0001;
      return sd;
   endfunction

   // One memory instruction through MEM: aw cycles without addr_ok, dw cycles of
   // data_ok delay beyond the best case, wbs cycles of WB stop starting at completion.
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] sd,
                         input logic [31:0] rd, input int aw, input int dw, input int wbs);
      ex_to_mem_t  e;
      logic        is_st, exp_st;
      logic [31:0] exp_a, exp_v, pc;
      logic [4:0]  wa;
      logic [65:0] hl;
      is_st = (op >= OP_SW);
      exp_a = m_addr(op, a);
      pc    = $urandom;
      wa    = 5'($urandom_range(1, 31));
      hl    = {2'($urandom), $urandom, $urandom};
      e.pc = pc; e.mem_en = 1'b1; e.mem_we = is_st; e.mem_op = op; e.rf_we = ~is_st;
      e.rf_waddr = wa; e.alu_result = a; e.store_data = sd;
      @(negedge clk);
      ex_bus = e;
      ex1    = hl;
      @(posedge clk); #1;
      ex_bus = '0;
      for (int i = 0; i <= aw; i++) begin
         addr_ok = (i == aw);
         @(negedge clk);
         exp_st = is_st ? (i < aw) : 1'b1;
         check("req", 70'(req), 70'(1));
         check("addr", 70'(addr), 70'(exp_a));
         check("wr", 70'(wr), 70'(is_st));
         check("stall_a", 70'(stallreq), 70'(exp_st));
         check("fwd_a", 70'(id_bus[37]), 70'(0));
         if (is_st) begin
            check("wstrb", 70'(wstrb), 70'(m_strb(op, exp_a)));
            check("wdata", 70'(wdata), 70'(m_wdata(op, sd)));
         end
         if (i == 0) check("wb1", 70'(wb1), 70'(hl));
         if (is_st && i == aw) check("st_wb", wb_bus, {pc, 1'b0, wa, a});
         @(posedge clk); #1;
      end
      addr_ok = 1'b0;
      if (!is_st) begin
         exp_v = m_load(op, rd, exp_a);
         for (int j = 0; j <= dw; j++) begin
            data_ok = (j == dw);
            rdata   = (j == dw) ? rd : $urandom;
            wb_stop = (j == dw) && (wbs > 0);
            @(negedge clk);
            check("req_r", 70'(req), 70'(0));
            check("stall_r", 70'(stallreq), 70'(j < dw));
            check("fwd_r", 70'(id_bus[37]), 70'(j == dw));
            if (j == dw) check("ld_wb", wb_bus, {pc, 1'b1, wa, exp_v});
            @(posedge clk); #1;
         end
         data_ok = 1'b0;
         rdata   = $urandom;
         for (int k = 1; k < wbs; k++) begin
            @(negedge clk);
            check("hold_req", 70'(req), 70'(0));
            check("hold_stall", 70'(stallreq), 70'(0));
            check("hold_wb", wb_bus, {pc, 1'b1, wa, exp_v});
            @(posedge clk); #1;
         end
         wb_stop = 1'b0;
      end
   endtask

   initial begin
      ex_to_mem_t  e;
      logic [2:0]  op;
      logic [31:0] a;
      rst = 1'b0; ex_bus = '0; ex1 = '0; addr_ok = 1'b0; data_ok = 1'b0;
      rdata = 32'h0; wb_stop = 1'b0; bubble = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_req", 70'(req), 70'(0));
      check("rst_stall", 70'(stallreq), 70'(0));
      check("rst_wb", wb_bus, 70'(0));
      check("rst_wb1", 70'(wb1), 70'(0));
      check("rst_id", 70'(id_bus), 70'(0));
      check("rst_sram", 70'({wstrb, addr, wdata}), 70'(0));
      @(posedge clk); #1;
      rst = 1'b1;

      // LB at 0x1003, best case: result 0xFFFFFF80
      run_op(OP_LB, 32'h0000_1003, 32'h0, 32'h80AB_CD12, 0, 0, 0);
      // SH at 0x2002, immediate addr_ok
      run_op(OP_SH, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0, 0);
      // LW with 3 withheld addr_ok cycles, data_ok 2 cycles after addr_ok
      run_op(OP_LW, 32'h0000_4440, 32'h0, 32'h1234_5678, 3, 1, 0);
      // LW completes while WB stopped for 4 cycles
      run_op(OP_LW, 32'h0000_5000, 32'h0, 32'hCAFE_F00D, 0, 0, 4);

      // Reset while waiting for data_ok
      e = '0; e.mem_en = 1'b1; e.rf_we = 1'b1; e.rf_waddr = 5'd3;
      e.alu_result = 32'h0000_6000; e.mem_op = OP_LW; e.pc = 32'h0000_0040;
      @(negedge clk); ex_bus = e;
      @(posedge clk); #1; ex_bus = '0; addr_ok = 1'b1;
      @(negedge clk); check("rr_req", 70'(req), 70'(1));
      @(posedge clk); #1; addr_ok = 1'b0;
      @(negedge clk); check("rr_wait", 70'(stallreq), 70'(1));
      #1 rst = 1'b0;
      #1;
      check("rr_req0", 70'(req), 70'(0));
      check("rr_stall0", 70'(stallreq), 70'(0));
      check("rr_wb0", wb_bus, 70'(0));
      @(posedge clk); #1; rst = 1'b1; data_ok = 1'b1; rdata = 32'hDEAD_BEEF;
      @(negedge clk);
      check("late_req", 70'(req), 70'(0));
      check("late_stall", 70'(stallreq), 70'(0));
      check("late_wb", wb_bus, 70'(0));
      @(posedge clk); #1; data_ok = 1'b0;
      run_op(OP_LHU, 32'h0000_3000, 32'h0, 32'h0000_8001, 0, 0, 0);

      // Misaligned LW at 0x1002
`ifdef MEM_UNALIGNED_EXC_EN
      e = '0; e.mem_en = 1'b1; e.rf_we = 1'b1; e.rf_waddr = 5'd9;
      e.alu_result = 32'h0000_1002; e.mem_op = OP_LW;
      @(negedge clk); ex_bus = e;
      @(posedge clk); #1; ex_bus = '0;
      @(negedge clk);
      check("mis_req", 70'(req), 70'(0));
      check("mis_adel", 70'(adel), 70'(1));
      check("mis_ades", 70'(ades), 70'(0));
      check("mis_stall", 70'(stallreq), 70'(0));
      check("mis_rfwe", 70'(wb_bus[37]), 70'(0));
      @(posedge clk); #1;
`else
      run_op(OP_LW, 32'h0000_1002, 32'h0, 32'h89AB_CDEF, 0, 0, 0);
`endif

      // Non-memory entries: capture, bubble, hold under WB stop
      e = '0; e.pc = 32'h400; e.rf_we = 1'b1; e.rf_waddr = 5'd7; e.alu_result = 32'h1234;
      @(negedge clk); ex_bus = e; ex1 = 66'h3_0000_0001_0000_0002;
      @(posedge clk); #1;
      check("alu_wb", wb_bus, {32'h400, 1'b1, 5'd7, 32'h1234});
      check("alu_id", 70'(id_bus), 70'({1'b1, 5'd7, 32'h1234}));
      check("alu_wb1", 70'(wb1), 70'(66'h3_0000_0001_0000_0002));
      e.pc = 32'h404; e.alu_result = 32'h5678;
      ex_bus = e; bubble = 1'b1;
      @(posedge clk); #1;
      check("bub_wb", wb_bus, 70'(0));
      check("bub_wb1", 70'(wb1), 70'(0));
      bubble = 1'b0;
      @(posedge clk); #1;
      e.pc = 32'h408; e.alu_result = 32'h9ABC;
      ex_bus = e; wb_stop = 1'b1;
      @(posedge clk); #1;
      check("hold_alu", wb_bus, {32'h404, 1'b1, 5'd7, 32'h5678});
      wb_stop = 1'b0;
      @(posedge clk); #1;
      check("next_alu", wb_bus, {32'h408, 1'b1, 5'd7, 32'h9ABC});
      ex_bus = '0;

      // Randomized accesses
      for (int n = 0; n < 40; n++) begin
         op = 3'($urandom_range(0, 7));
         a  = $urandom;
`ifdef MEM_UNALIGNED_EXC_EN
         a  = m_addr(op, a);
`endif
         run_op(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 2),
                $urandom_range(0, 2));
      end

      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
